fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls instruction fetch for the KLP32 core. Owns the next-PC register, issues requests to instruction memory through a req/rvalid handshake, and buffers returned instructions.
- Presents each buffered instruction to decode with a valid/ready handshake.
- Handles branch/jump redirects from the execute-stage ALU, including flushing the buffer and discarding an in-flight response.
- Replaces the free-running pc/pc_select_mux chain when instruction memory has variable latency.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- BUF_DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_redirect  in  1  taken branch/jump this cycle (pc_sel)
- i_redirect_pc  in  32  ALU target address
- o_imem_req  out  1  fetch request, accepted the same cycle it is asserted
- o_imem_addr  out  32  request address, word aligned
- i_imem_rvalid  in  1  response valid, >= 1 cycle after req, in order
- i_imem_rdata  in  32  instruction word
- o_valid  out  1  buffer head valid to decode
- i_ready  in  1  decode accepts head
- o_inst  out  32  head instruction
- o_pc  out  32  head PC
- o_pc_inc  out  32  head PC + 4
- o_misaligned  out  1  one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - pc_next = RESET_PC; buffer empty; state RUN; outstanding = 0.
  - o_imem_req = 0, o_valid = 0, o_inst = o_pc = o_pc_inc = 0, o_misaligned = 0.
  - Reset mid-operation discards any in-flight response. An rvalid arriving after reset is ignored while outstanding = 0.
- Outstanding requests: at most one.
- States:
  - RUN: no request outstanding.
  - WAIT: one request outstanding; its response is kept.
  - DROP: one request outstanding; its response is discarded.
- Occupancy and space:
  - occ_next = count + push - pop, where push = rvalid in WAIT and pop = o_valid & i_ready.
  - space = (occ_next < BUF_DEPTH).
- Request issue (o_imem_req is combinational):
  - o_imem_req = !reset & !i_redirect & space & (state==RUN | i_imem_rvalid).
  - o_imem_addr = pc_next.
  - On issue: pc_next <= pc_next + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Transitions:
  - RUN -> WAIT on issue.
  - WAIT with rvalid: push {pc, rdata}; go to WAIT if it issues again, otherwise RUN.
  - DROP with rvalid: discard the data; go to WAIT if it issues (at the target), otherwise RUN.
- Back-to-back: an issue in the same cycle as rvalid gives 1 instr/cycle with 1-cycle memory.
- Redirect (i_redirect = 1), which has priority over everything:
  - The buffer is flushed; o_valid = 0 next cycle.
  - A pop in the same cycle is considered consumed; decode handles its own flush.
  - pc_next <= {i_redirect_pc[31:2], 2'b00}. o_misaligned pulses next cycle if bits[1:0] != 0.
  - No request is issued in the redirect cycle. The first request to the target comes on the next cycle, so redirect-to-request latency is 1 cycle.
  - State handling:
    - WAIT without rvalid -> DROP.
    - WAIT or DROP with rvalid in the same cycle: the response is discarded -> RUN.
    - DROP without rvalid stays DROP, with the target updated.
    - RUN stays RUN.
- Buffer entries store pc, inst and pc+4. Outputs come from the head entry. o_valid = (count != 0).
- Full buffer with i_ready = 0: no issue. When a pop occurs, an issue is allowed in the same cycle.
- Latency: first request on the cycle after reset deasserts. o_valid rises the cycle after rvalid.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {RUN, WAIT, DROP}.
  - fetch_entry_t struct {pc, pc_inc, inst}.
  - constants INST_BYTES = 4 and DEFAULT_RESET_PC.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with push, pop, flush, count, head outputs. Flush has priority over push.

Test Plan:
- Reset with RESET_PC = 0x100, memory latency 1, i_ready = 1 -> requests 0x100, 0x104, 0x108 on consecutive cycles; o_valid continuous from cycle 2; o_pc_inc = o_pc + 4.
- i_ready = 0 for 6 cycles, BUF_DEPTH = 2 -> exactly 2 entries buffered, then o_imem_req = 0. Release i_ready -> entries 0x0 then 0x4 delivered in order, with no loss or duplicate.
- Latency-3 memory; redirect to 0x200 one cycle after a request to 0x8 -> state DROP; the 0x8 response is discarded; next request 0x200; first o_pc delivered = 0x200.
- Redirect to 0x40 in the same cycle as rvalid in WAIT -> data discarded, state RUN, next cycle o_imem_addr = 0x40, o_valid = 0 until the 0x40 response.
- RESET_PC = 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Redirect to 0x203 -> request 0x200 and one o_misaligned pulse.
- Assert reset while a request is outstanding -> all outputs return to reset values; a late rvalid produces no o_valid; the next request is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the KLP32 instruction fetch path.
package fetch_pkg;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned INST_BYTES       = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_inc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched instructions; flush wins over push.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  fetch_entry_t     i_entry,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output fetch_entry_t     o_head
);
    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (!reset && !i_flush && i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/fetch_sequencer.sv
// KLP32 fetch control: next-PC, single-outstanding imem handshake,
// instruction buffer to decode, and redirect/flush handling.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_inc,
    output logic        o_misaligned
);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_t     r_state;
    logic [31:0]      r_pc_next;
    logic [31:0]      r_req_pc;
    logic             r_misaligned;
    logic [CNT_W-1:0] w_count;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_push;
    logic             w_pop;
    logic             w_space;
    logic             w_issue;
    fetch_entry_t     w_entry;
    fetch_entry_t     w_head;

    // Space is judged on post-cycle occupancy so a pop frees a slot immediately.
    assign w_pop      = o_valid & i_ready;
    assign w_push     = (r_state == WAIT) & i_imem_rvalid;
    assign w_occ_next = OCC_W'(w_count) + OCC_W'(w_push) - OCC_W'(w_pop);
    assign w_space    = w_occ_next < OCC_W'(BUF_DEPTH);
    assign w_issue    = !reset & !i_redirect & w_space
                      & ((r_state == RUN) | i_imem_rvalid);

    assign w_entry = '{pc: r_req_pc, pc_inc: r_req_pc + 32'(INST_BYTES), inst: i_imem_rdata};

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc_next    <= RESET_PC;
            r_req_pc     <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= i_redirect & (i_redirect_pc[1:0] != 2'b00);
            if (w_issue) begin
                r_pc_next <= r_pc_next + 32'(INST_BYTES);
                r_req_pc  <= r_pc_next;
            end
            if (i_redirect) begin
                // An outstanding request whose data has not arrived must be dropped.
                r_pc_next <= {i_redirect_pc[31:2], 2'b00};
                r_state   <= (r_state == RUN || i_imem_rvalid) ? RUN : DROP;
            end else begin
                case (r_state)
                    RUN:        if (w_issue) r_state <= WAIT;
                    WAIT, DROP: if (i_imem_rvalid) r_state <= w_issue ? WAIT : RUN;
                    default:    r_state <= RUN;
                endcase
            end
        end
    end

    assign o_imem_req   = w_issue;
    assign o_imem_addr  = r_pc_next;
    assign o_valid      = (w_count != '0);
    assign o_inst       = w_head.inst;
    assign o_pc         = w_head.pc;
    assign o_pc_inc     = w_head.pc_inc;
    assign o_misaligned = r_misaligned;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a fixed-latency imem responder.
module tb_fetch_sequencer;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata  = '0;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_pc_inc;
    logic        o_misaligned;

    int vec = 0;
    int err = 0;

    int          m_lat = 1;
    logic        m_clr = 1'b1;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    fetch_sequencer #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .o_pc_inc      (o_pc_inc),
        .o_misaligned  (o_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // Memory: a request accepted at an edge answers m_lat cycles later.
    always @(posedge clk) begin
        i_imem_rvalid <= 1'b0;
        if (m_clr) begin
            m_pend <= 1'b0;
        end else begin
            if (m_pend) begin
                if (m_cnt == 1) begin
                    i_imem_rvalid <= 1'b1;
                    i_imem_rdata  <= inst_of(m_addr);
                    m_pend        <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (o_imem_req) begin
                if (m_lat == 1) begin
                    i_imem_rvalid <= 1'b1;
                    i_imem_rdata  <= inst_of(o_imem_addr);
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= m_lat - 1;
                    m_addr <= o_imem_addr;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic rdy, input int lat);
        reset = 1'b1; m_clr = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
        i_ready = rdy; m_lat = lat;
        cyc(); cyc(); cyc();
        reset = 1'b0; m_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_clr = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
        i_ready = 1'b1; m_lat = 1;
        cyc(); cyc(); #1;
        vec++; if (o_imem_req !== 1'b0) begin err++; $display("FAIL rst_req got %b want 0", o_imem_req); end
        vec++; if (o_valid !== 1'b0) begin err++; $display("FAIL rst_valid got %b want 0", o_valid); end
        vec++; if (o_inst !== 32'h0) begin err++; $display("FAIL rst_inst got %h want 0", o_inst); end
        vec++; if (o_pc !== 32'h0 || o_pc_inc !== 32'h0) begin err++; $display("FAIL rst_pc got %h/%h want 0/0", o_pc, o_pc_inc); end
        vec++; if (o_misaligned !== 1'b0) begin err++; $display("FAIL rst_mis got %b want 0", o_misaligned); end
        cyc(); reset = 1'b0; m_clr = 1'b0; #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin err++; $display("FAIL rst_first_req got %b/%h want 1/%h", o_imem_req, o_imem_addr, RST_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        apply_reset(1'b1, 1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            #1;
            exp = RST_PC + 32'(4 * k);
            vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== exp) begin err++; $display("FAIL stream_req k=%0d got %b/%h want 1/%h", k, o_imem_req, o_imem_addr, exp); end
            vec++; if (o_valid !== (k >= 2)) begin err++; $display("FAIL stream_valid k=%0d got %b want %b", k, o_valid, (k >= 2)); end
            if (k >= 2) begin
                exp = RST_PC + 32'(4 * (k - 2));
                vec++; if (o_pc !== exp || o_pc_inc !== exp + 32'd4 || o_inst !== inst_of(exp)) begin err++; $display("FAIL stream_head k=%0d got %h/%h/%h want %h/%h/%h", k, o_pc, o_pc_inc, o_inst, exp, exp + 32'd4, inst_of(exp)); end
            end
        end
    endtask

    task automatic test_stall();
        apply_reset(1'b0, 1);
        i_redirect = 1'b1; i_redirect_pc = 32'h0; #1;
        vec++; if (o_imem_req !== 1'b0) begin err++; $display("FAIL stall_redir_req got %b want 0", o_imem_req); end
        cyc(); i_redirect = 1'b0; #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin err++; $display("FAIL stall_req0 got %b/%h want 1/0", o_imem_req, o_imem_addr); end
        cyc(); #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin err++; $display("FAIL stall_req4 got %b/%h want 1/4", o_imem_req, o_imem_addr); end
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            vec++; if (o_imem_req !== 1'b0 || o_valid !== 1'b1 || o_pc !== 32'h0) begin err++; $display("FAIL stall_full k=%0d got req=%b valid=%b pc=%h want 0/1/0", k, o_imem_req, o_valid, o_pc); end
        end
        cyc(); i_ready = 1'b1; #1;
        vec++; if (o_pc !== 32'h0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin err++; $display("FAIL stall_release got pc=%h req=%b addr=%h want 0/1/8", o_pc, o_imem_req, o_imem_addr); end
        cyc(); #1;
        vec++; if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_inst !== inst_of(32'h4)) begin err++; $display("FAIL stall_second got %b/%h/%h want 1/4/%h", o_valid, o_pc, o_inst, inst_of(32'h4)); end
        cyc(); #1;
        vec++; if (o_valid !== 1'b1 || o_pc !== 32'h8) begin err++; $display("FAIL stall_third got %b/%h want 1/8", o_valid, o_pc); end
    endtask

    task automatic test_drop();
        apply_reset(1'b1, 3);
        i_redirect = 1'b1; i_redirect_pc = 32'h8; #1;
        cyc(); i_redirect = 1'b0; #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin err++; $display("FAIL drop_req8 got %b/%h want 1/8", o_imem_req, o_imem_addr); end
        cyc(); i_redirect = 1'b1; i_redirect_pc = 32'h200; #1;
        vec++; if (o_imem_req !== 1'b0) begin err++; $display("FAIL drop_redir_req got %b want 0", o_imem_req); end
        cyc(); i_redirect = 1'b0; #1;
        vec++; if (o_imem_req !== 1'b0 || o_valid !== 1'b0) begin err++; $display("FAIL drop_wait got %b/%b want 0/0", o_imem_req, o_valid); end
        cyc(); #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h200 || o_valid !== 1'b0) begin err++; $display("FAIL drop_target got %b/%h/%b want 1/200/0", o_imem_req, o_imem_addr, o_valid); end
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            vec++; if (o_imem_req !== 1'b0 || o_valid !== 1'b0) begin err++; $display("FAIL drop_discard k=%0d got %b/%b want 0/0", k, o_imem_req, o_valid); end
        end
        cyc(); #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h204 || o_valid !== 1'b0) begin err++; $display("FAIL drop_next got %b/%h/%b want 1/204/0", o_imem_req, o_imem_addr, o_valid); end
        cyc(); #1;
        vec++; if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_inst !== inst_of(32'h200)) begin err++; $display("FAIL drop_first got %b/%h/%h want 1/200/%h", o_valid, o_pc, o_inst, inst_of(32'h200)); end
    endtask

    task automatic test_redirect_rvalid();
        apply_reset(1'b1, 1);
        #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin err++; $display("FAIL rr_first got %b/%h want 1/%h", o_imem_req, o_imem_addr, RST_PC); end
        cyc(); i_redirect = 1'b1; i_redirect_pc = 32'h40; #1;
        vec++; if (o_imem_req !== 1'b0) begin err++; $display("FAIL rr_redir_req got %b want 0", o_imem_req); end
        cyc(); i_redirect = 1'b0; #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40 || o_valid !== 1'b0) begin err++; $display("FAIL rr_target got %b/%h/%b want 1/40/0", o_imem_req, o_imem_addr, o_valid); end
        cyc(); #1;
        vec++; if (o_imem_addr !== 32'h44 || o_valid !== 1'b0) begin err++; $display("FAIL rr_next got %h/%b want 44/0", o_imem_addr, o_valid); end
        cyc(); #1;
        vec++; if (o_valid !== 1'b1 || o_pc !== 32'h40) begin err++; $display("FAIL rr_deliver got %b/%h want 1/40", o_valid, o_pc); end
    endtask

    task automatic test_wrap_misaligned();
        apply_reset(1'b1, 1);
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8; #1;
        cyc(); i_redirect = 1'b0; #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFF8) begin err++; $display("FAIL wrap_req0 got %b/%h want 1/fffffff8", o_imem_req, o_imem_addr); end
        cyc(); #1;
        vec++; if (o_imem_addr !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_req1 got %h want fffffffc", o_imem_addr); end
        cyc(); #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin err++; $display("FAIL wrap_req2 got %b/%h want 1/0", o_imem_req, o_imem_addr); end
        vec++; if (o_pc !== 32'hFFFF_FFF8 || o_pc_inc !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_head0 got %h/%h want fffffff8/fffffffc", o_pc, o_pc_inc); end
        cyc(); i_redirect = 1'b1; i_redirect_pc = 32'h203; #1;
        vec++; if (o_pc !== 32'hFFFF_FFFC || o_pc_inc !== 32'h0 || o_misaligned !== 1'b0 || o_imem_req !== 1'b0) begin err++; $display("FAIL wrap_head1 got %h/%h mis=%b req=%b want fffffffc/0/0/0", o_pc, o_pc_inc, o_misaligned, o_imem_req); end
        cyc(); i_redirect = 1'b0; #1;
        vec++; if (o_misaligned !== 1'b1 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h200 || o_valid !== 1'b0) begin err++; $display("FAIL mis_pulse got mis=%b req=%b addr=%h valid=%b want 1/1/200/0", o_misaligned, o_imem_req, o_imem_addr, o_valid); end
        cyc(); #1;
        vec++; if (o_misaligned !== 1'b0 || o_imem_addr !== 32'h204) begin err++; $display("FAIL mis_end got mis=%b addr=%h want 0/204", o_misaligned, o_imem_addr); end
    endtask

    task automatic test_reset_midflight();
        apply_reset(1'b0, 3);
        #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin err++; $display("FAIL mid_req0 got %b/%h want 1/%h", o_imem_req, o_imem_addr, RST_PC); end
        cyc(); cyc(); cyc(); #1;
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h104) begin err++; $display("FAIL mid_req1 got %b/%h want 1/104", o_imem_req, o_imem_addr); end
        cyc(); #1;
        vec++; if (o_valid !== 1'b1 || o_pc !== RST_PC) begin err++; $display("FAIL mid_head got %b/%h want 1/%h", o_valid, o_pc, RST_PC); end
        cyc(); reset = 1'b1; #1;
        vec++; if (o_imem_req !== 1'b0) begin err++; $display("FAIL mid_rst_req got %b want 0", o_imem_req); end
        cyc(); reset = 1'b0; i_ready = 1'b1; #1;
        vec++; if (o_valid !== 1'b0 || o_inst !== 32'h0 || o_pc !== 32'h0 || o_pc_inc !== 32'h0 || o_misaligned !== 1'b0) begin err++; $display("FAIL mid_rst_out got v=%b inst=%h pc=%h inc=%h mis=%b want all 0", o_valid, o_inst, o_pc, o_pc_inc, o_misaligned); end
        vec++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin err++; $display("FAIL mid_restart got %b/%h want 1/%h", o_imem_req, o_imem_addr, RST_PC); end
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            vec++; if (o_valid !== 1'b0) begin err++; $display("FAIL mid_late k=%0d got %b want 0", k, o_valid); end
        end
        cyc(); #1;
        vec++; if (o_valid !== 1'b1 || o_pc !== RST_PC || o_inst !== inst_of(RST_PC)) begin err++; $display("FAIL mid_deliver got %b/%h/%h want 1/%h/%h", o_valid, o_pc, o_inst, RST_PC, inst_of(RST_PC)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drop();
        test_redirect_rvalid();
        test_wrap_misaligned();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
